alu_seq_display: RTL and testbench

Parametrised, multi-cycle ALU with an integrated decimal seven-segment scanner. It latches operands on a start handshake and executes single-cycle logic/add ops or iterative multiply/divide. It converts the result to BCD with a sequential double-dabble, then continuously multiplexes the op code and decimal result onto the board's 8-anode display. It runs on the divided display clock and replaces the fixed 4-bit, combinational-result ALU.

---
 rtl/alu_seq_display.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_seq_display.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_display.sv
// alu_seq_display: multi-cycle ALU (shift-add multiply, restoring divide)
// with a sequential double-dabble BCD converter and a scanned, active-low
// seven-segment display. The op code is shown on anode[7] and the decimal
// result on anode[DIGITS-1:0].
module alu_seq_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             new_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [6:0]       display,
    output logic [7:0]       anode
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CONV} state_t;

    state_t r_state, w_state_next;

    logic [WIDTH-1:0]   r_a, r_b;
    logic [3:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_quo, r_rem;
    logic [WIDTH-1:0]   r_res_pend, r_bin;
    logic               r_ovf_pend, r_dbz_pend;
    logic [BW-1:0]      r_bcd_work, r_bcd;
    logic [WIDTH-1:0]   r_result;
    logic               r_ovf, r_dbz, r_done;
    logic [SW-1:0]      r_scan;
    logic [7:0]         r_an_s1, r_anode;
    logic [6:0]         r_seg_s1, r_display;

    logic               w_iter, w_last_step, w_exec_finish;
    logic [WIDTH:0]     w_mul_sum, w_sum, w_rem_shift;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_next, w_quo_next;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf, w_dbz;
    logic [BW-1:0]      w_bcd_adj, w_bcd_next;
    logic [DIGITS-1:0]  w_blank;
    logic [3:0]         w_scan_nib;
    logic               w_scan_blank;
    logic [7:0]         w_scan_an;
    int                 w_digit_idx;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // MUL and DIV/MOD with nonzero divisor iterate WIDTH cycles; all else takes one.
    assign w_iter        = (r_op == 4'h4) || (((r_op == 4'h9) || (r_op == 4'hD)) && (r_b != '0));
    assign w_last_step   = (r_cnt == CW'(WIDTH - 1));
    assign w_exec_finish = !w_iter || w_last_step;

    // Shift-add multiply step: conditionally add a into the high half, shift right.
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    // Restoring division step: dividend bits enter the remainder from r_quo's MSB.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_ge    = (w_rem_shift >= {1'b0, r_b});
    assign w_rem_next  = w_div_ge ? WIDTH'(w_rem_shift - {1'b0, r_b}) : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_div_ge};

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // Result and flags of the latched op; iterative ops are only consumed on their last step.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_dbz = 1'b0;
        case (r_op)
            4'h0: begin w_res = r_a + WIDTH'(1); w_ovf = &r_a; end
            4'h1: begin w_res = r_b + WIDTH'(1); w_ovf = &r_b; end
            4'h2: begin w_res = r_a - r_b; w_ovf = (r_a < r_b); end
            4'h3: begin w_res = w_sum[WIDTH-1:0]; w_ovf = w_sum[WIDTH]; end
            4'h4: begin w_res = w_prod_next[WIDTH-1:0]; w_ovf = |w_prod_next[2*WIDTH-1:WIDTH]; end
            4'h5: w_res = r_a >> 1;
            4'h6: begin w_res = r_a << 1; w_ovf = r_a[WIDTH-1]; end
            4'h7: w_res = r_b >> 1;
            4'h8: begin w_res = r_b << 1; w_ovf = r_b[WIDTH-1]; end
            4'h9, 4'hD: begin
                if (r_b == '0) begin
                    w_res = '1;
                    w_dbz = 1'b1;
                end else begin
                    w_res = (r_op == 4'h9) ? w_rem_next : w_quo_next;
                end
            end
            4'hA: w_res = r_a & r_b;
            4'hB: w_res = r_a | r_b;
            4'hC: w_res = r_a ^ r_b;
            default: w_res = '0;
        endcase
    end

    // Double-dabble: add 3 to every BCD nibble >= 5, then shift in the next binary bit.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dabble
            assign w_bcd_adj[4*gi +: 4] = (r_bcd_work[4*gi +: 4] >= 4'd5)
                                        ? r_bcd_work[4*gi +: 4] + 4'd3
                                        : r_bcd_work[4*gi +: 4];
        end
    endgenerate
    assign w_bcd_next = {w_bcd_adj[BW-2:0], r_bin[WIDTH-1]};

    // State register.
    always_ff @(posedge new_clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_EXEC;
            ST_EXEC: if (w_exec_finish) w_state_next = ST_CONV;
            ST_CONV: if (w_last_step) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand latch, arithmetic iteration, BCD conversion and result commit.
    always_ff @(posedge new_clk) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_op <= '0; r_cnt <= '0;
            r_prod <= '0; r_quo <= '0; r_rem <= '0;
            r_res_pend <= '0; r_ovf_pend <= 1'b0; r_dbz_pend <= 1'b0;
            r_bin <= '0; r_bcd_work <= '0; r_bcd <= '0;
            r_result <= '0; r_ovf <= 1'b0; r_dbz <= 1'b0; r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_op   <= op;
                        r_cnt  <= '0;
                        r_prod <= {{WIDTH{1'b0}}, b};
                        r_quo  <= a;
                        r_rem  <= '0;
                    end
                end
                ST_EXEC: begin
                    r_prod <= w_prod_next;
                    r_quo  <= w_quo_next;
                    r_rem  <= w_rem_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_exec_finish) begin
                        r_res_pend <= w_res;
                        r_ovf_pend <= w_ovf;
                        r_dbz_pend <= w_dbz;
                        r_bin      <= w_res;
                        r_bcd_work <= '0;
                        r_cnt      <= '0;
                    end
                end
                ST_CONV: begin
                    r_bin      <= r_bin << 1;
                    r_bcd_work <= w_bcd_next;
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_last_step) begin
                        r_result <= r_res_pend;
                        r_ovf    <= r_ovf_pend;
                        r_dbz    <= r_dbz_pend;
                        r_bcd    <= w_bcd_next;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking: a digit is blank if it and every digit above it are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        w_blank  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero && (r_bcd[4*i +: 4] == 4'd0);
            w_blank[i] = all_zero;
        end
    end

    // Select the nibble and anode for the current scan index.
    always_comb begin
        w_digit_idx  = int'(r_scan) - 1;
        w_scan_nib   = r_op;
        w_scan_blank = 1'b0;
        w_scan_an    = 8'h7F;
        if (r_scan != '0) begin
            w_scan_nib   = r_bcd[4*w_digit_idx +: 4];
            w_scan_blank = w_blank[w_digit_idx];
            w_scan_an    = ~(8'd1 << w_digit_idx);
        end
    end

    // Scan index and two-stage registered anode/cathode pair (always updated together).
    always_ff @(posedge new_clk) begin
        if (rst) begin
            r_scan    <= '0;
            r_an_s1   <= 8'hFF;
            r_seg_s1  <= 7'h7F;
            r_anode   <= 8'hFF;
            r_display <= 7'h7F;
        end else begin
            r_scan    <= (r_scan == SW'(DIGITS)) ? '0 : r_scan + SW'(1);
            r_an_s1   <= w_scan_an;
            r_seg_s1  <= w_scan_blank ? 7'h7F : hex_glyph(w_scan_nib);
            r_anode   <= r_an_s1;
            r_display <= r_seg_s1;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;
    assign display     = r_display;
    assign anode       = r_anode;

endmodule

// File: tb/tb_alu_seq_display.sv
// Scoreboard bench for alu_seq_display (WIDTH=8, DIGITS=3): stimulus pushes
// expected completions, a monitor pops and compares on every done pulse.
module tb_alu_seq_display;

    logic       new_clk;
    logic       rst;
    logic [7:0] a, b;
    logic [3:0] op;
    logic       start;
    logic       busy, done, overflow, div_by_zero;
    logic [7:0] result;
    logic [6:0] display;
    logic [7:0] anode;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        logic       dbz;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    alu_seq_display #(.WIDTH(8), .DIGITS(3)) dut (
        .new_clk(new_clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .div_by_zero(div_by_zero), .display(display), .anode(anode)
    );

    initial new_clk = 1'b0;
    always #5 new_clk = ~new_clk;

    always @(posedge new_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every completion is matched against the oldest expectation.
    always @(negedge new_clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result=%0d at cycle %0d, required no completion",
                         result, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", {24'd0, result}, {24'd0, mon_e.res});
                chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                chk("done_cycle", cyc, mon_e.cyc);
                $display("done: result=%0d ovf=%0b dbz=%0b cycle=%0d", result, overflow,
                         div_by_zero, cyc);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic eo, input logic ed, input int lat);
        exp_t e;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge new_clk);
        @(negedge new_clk);
        start = 1'b0;
        chk("busy_accept", {31'd0, busy}, 32'd1);
        e.res = er;
        e.ovf = eo;
        e.dbz = ed;
        e.cyc = cyc + lat;
        sb.push_back(e);
        $display("issue: op=%0h a=%0d b=%0d expect=%0d ovf=%0b dbz=%0b at cycle %0d",
                 o, x, y, er, eo, ed, cyc);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge new_clk);
        #1;
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge new_clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL timeout: got busy=%0b pending=%0d, required idle", busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic eo, input logic ed, input int lat);
        issue(o, x, y, er, eo, ed, lat);
        wait_idle();
    endtask

    // Checks one full scan: op glyph, units, tens, hundreds, then wrap to the op.
    task automatic chk_scan(input logic [6:0] g_op, input logic [6:0] g0,
                            input logic [6:0] g1, input logic [6:0] g2);
        int n = 0;
        repeat (3) @(negedge new_clk);
        while (anode !== 8'h7F && n < 12) begin
            @(negedge new_clk);
            n++;
        end
        chk("scan_sync_anode", {24'd0, anode}, 32'h7F);
        chk("scan_op_glyph", {25'd0, display}, {25'd0, g_op});
        @(negedge new_clk);
        chk("scan_units_anode", {24'd0, anode}, 32'hFE);
        chk("scan_units_glyph", {25'd0, display}, {25'd0, g0});
        @(negedge new_clk);
        chk("scan_tens_anode", {24'd0, anode}, 32'hFD);
        chk("scan_tens_glyph", {25'd0, display}, {25'd0, g1});
        @(negedge new_clk);
        chk("scan_hund_anode", {24'd0, anode}, 32'hFB);
        chk("scan_hund_glyph", {25'd0, display}, {25'd0, g2});
        @(negedge new_clk);
        chk("scan_wrap_anode", {24'd0, anode}, 32'h7F);
        $display("scan: op/units/tens/hundreds checked");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = '0;
        repeat (3) @(posedge new_clk);
        @(negedge new_clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_anode", {24'd0, anode}, 32'hFF);
        chk("rst_display", {25'd0, display}, 32'h7F);
        rst = 1'b0;
        @(negedge new_clk);

        // Add with carry; display "3", 4, 4, hundreds blank.
        run(4'h3, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 9);
        chk_scan(7'h30, 7'h19, 7'h19, 7'h7F);
        // Multiply.
        run(4'h4, 8'd15, 8'd17, 8'd255, 1'b0, 1'b0, 16);
        run(4'h4, 8'd16, 8'd16, 8'd0, 1'b1, 1'b0, 16);
        run(4'h4, 8'd12, 8'd11, 8'd132, 1'b0, 1'b0, 16);
        // Divide / modulo, including divide by zero.
        run(4'hD, 8'd200, 8'd7, 8'd28, 1'b0, 1'b0, 16);
        run(4'h9, 8'd200, 8'd7, 8'd4, 1'b0, 1'b0, 16);
        run(4'h9, 8'd255, 8'd16, 8'd15, 1'b0, 1'b0, 16);
        run(4'hD, 8'd200, 8'd0, 8'd255, 1'b0, 1'b1, 9);
        chk_scan(7'h21, 7'h12, 7'h12, 7'h24);
        run(4'h9, 8'd5, 8'd0, 8'd255, 1'b0, 1'b1, 9);
        // Increments, subtract, shifts.
        run(4'h0, 8'd255, 8'd3, 8'd0, 1'b1, 1'b0, 9);
        run(4'h1, 8'd4, 8'd9, 8'd10, 1'b0, 1'b0, 9);
        run(4'h2, 8'd50, 8'd8, 8'd42, 1'b0, 1'b0, 9);
        run(4'h5, 8'd9, 8'd0, 8'd4, 1'b0, 1'b0, 9);
        run(4'h6, 8'h81, 8'd0, 8'h02, 1'b1, 1'b0, 9);
        run(4'h7, 8'd0, 8'd9, 8'd4, 1'b0, 1'b0, 9);
        run(4'h8, 8'd0, 8'h40, 8'h80, 1'b0, 1'b0, 9);
        // Logic ops and reserved code.
        run(4'hA, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 9);
        run(4'hB, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 9);
        run(4'hC, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 9);
        run(4'hE, 8'd7, 8'd9, 8'd0, 1'b0, 1'b0, 9);
        // Small result blanks tens and hundreds.
        run(4'h3, 8'd2, 8'd3, 8'd5, 1'b0, 1'b0, 9);
        chk_scan(7'h30, 7'h12, 7'h7F, 7'h7F);

        // Back-to-back: second start raised in the done cycle of the first.
        issue(4'h3, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 9);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge new_clk);
            n++;
        end
        chk("b2b_done_seen", {31'd0, done}, 32'd1);
        issue(4'h2, 8'd1, 8'd2, 8'd255, 1'b1, 1'b0, 9);
        wait_idle();

        // Start while busy is ignored.
        issue(4'h4, 8'd15, 8'd17, 8'd255, 1'b0, 1'b0, 16);
        repeat (3) @(negedge new_clk);
        op    = 4'h3;
        a     = 8'd1;
        b     = 8'd1;
        start = 1'b1;
        @(negedge new_clk);
        start = 1'b0;
        chk("busy_during_mul", {31'd0, busy}, 32'd1);
        wait_idle();
        repeat (20) @(negedge new_clk);

        // Reset five edges into a multiply: abort without done, op cleared.
        op    = 4'h4;
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        @(posedge new_clk);
        @(negedge new_clk);
        start = 1'b0;
        repeat (4) @(negedge new_clk);
        rst = 1'b1;
        @(negedge new_clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_overflow", {31'd0, overflow}, 32'd0);
        @(negedge new_clk);
        chk("abort_anode", {24'd0, anode}, 32'hFF);
        chk("abort_display", {25'd0, display}, 32'h7F);
        rst = 1'b0;
        @(negedge new_clk);
        chk("rel_edge1_anode", {24'd0, anode}, 32'hFF);
        @(negedge new_clk);
        chk("rel_edge2_anode", {24'd0, anode}, 32'h7F);
        chk("rel_edge2_glyph", {25'd0, display}, 32'h40);
        @(negedge new_clk);
        chk("rel_edge3_anode", {24'd0, anode}, 32'hFE);
        chk("rel_edge3_glyph", {25'd0, display}, 32'h40);
        @(negedge new_clk);
        chk("rel_edge4_anode", {24'd0, anode}, 32'hFD);
        chk("rel_edge4_glyph", {25'd0, display}, 32'h7F);
        @(negedge new_clk);
        chk("rel_edge5_anode", {24'd0, anode}, 32'hFB);
        chk("rel_edge5_glyph", {25'd0, display}, 32'h7F);
        @(negedge new_clk);
        chk("rel_edge6_anode", {24'd0, anode}, 32'h7F);
        $display("reset release scan sequence checked");
        repeat (20) @(negedge new_clk);
        chk("final_queue_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
